cpu_timing_gen: RTL and testbench
=================================

# cpu_timing_gen

Beat/phase timing generator for the hardwired CPU controller. It produces the machine-cycle beats `w1`/`w2`/`w3` and the sub-beat strobe `t3` that the controller consumes. It also honours the controller's `short`, `long` and `stop` feedback to size each machine cycle. It sits between the board clock and the controller, replacing the behavioural clocking model used in simulation with synthesizable logic.

## Interface

Parameters:
- `PHASES`, default 4: clk cycles per beat, phases T1..T`PHASES`. Legal values are 2..16.
- `T3_PHASE`, default 2: zero-based phase index during which `t3` is high. Must be less than `PHASES`.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `clr`  in  1  reset, asynchronous, active-low.
- `qd`  in  1  start request, one-cycle pulse, already synchronized. Honoured only in IDLE.
- `step`  in  1  single-step mode: when high, the generator returns to IDLE after every machine cycle.
- `short`  in  1  from controller; the machine cycle is W1 only.
- `long`  in  1  from controller; the machine cycle is W1, W2, W3.
- `stop`  in  1  from controller; halt at the end of the current machine cycle.
- `w1`, `w2`, `w3`  out  1 each  beat indicators, one-hot or all zero.
- `t3`  out  1  phase strobe inside the active beat.
- `phase`  out  4  current phase index within the beat; 0 when idle.
- `running`  out  1  high whenever a beat is active.
- `cyc_end`  out  1  one-cycle pulse on the last clk of each machine cycle.

## Operation

- States: IDLE, W1, W2, W3. Each beat state lasts exactly `PHASES` clk cycles, counted by `phase` from 0 to `PHASES`-1.
- IDLE: when `qd`=1, go to W1 with phase 0. Otherwise stay in IDLE.
- Decisions are taken only on the last phase of a beat (phase = `PHASES`-1), using input values sampled on that edge:
  - End of W1: if `short`=1, the machine cycle ends. Otherwise go to W2.
  - End of W2: if `long`=1, go to W3. Otherwise the machine cycle ends.
  - End of W3: the machine cycle ends.
- Machine-cycle end: `cyc_end`=1 on that final clk.
  - If `stop`=1 or `step`=1, go to IDLE.
  - Otherwise go to W1 with phase 0.
- Changes to `short`, `long`, `stop` or `step` away from a decision point are ignored.
- If `short` and `long` are both 1 at the end of W1, `short` wins. `long` is not examined at the end of W1.
- `qd` is ignored outside IDLE.
- `t3` = 1 iff state ≠ IDLE and `phase` = `T3_PHASE`.
- `w1`, `w2` and `w3` are the registered decode of the state; at most one is high.
- Reset: `clr`=0 forces IDLE immediately, mid-beat included. While in reset all outputs are 0, including `phase`=0, `t3`=0 and `cyc_end`=0.

## Timing

- All outputs are registered or decoded directly from registers, with no combinational path from inputs to outputs. This excludes `cyc_end`, which is decoded from state, phase and the sampled `short`/`long` inputs.
- If `qd` is sampled at edge k, then `w1`=1 and `phase`=0 from edge k.
- Beat length is exactly `PHASES` cycles.
- Machine-cycle lengths: `PHASES`×1 (short), ×2 (normal) or ×3 (long).
- Back-to-back machine cycles have no idle gap: W1 phase 0 follows directly after `cyc_end`.
- Restart after IDLE needs a new `qd` pulse. There is a minimum of one IDLE cycle between machine cycles when stopping.

## Structure

- Package `cpu_timing_pkg` holds:
  - `beat_e` enum (IDLE, W1, W2, W3);
  - the default `PHASES` and `T3_PHASE` constants;
  - a `beat_onehot` function mapping `beat_e` to {w3,w2,w1}.
- One natural sub-module, `phase_counter`: a modulo-`PHASES` counter with enable and synchronous clear. It outputs `phase` and a `last` flag.
- The top level holds the beat FSM and the output decode.

## Test plan

All scenarios use `PHASES`=4 and `T3_PHASE`=2.

1. Reset, then `qd` at cycle 0 with short=long=0. Expected:
   - `w1` high in cycles 0–3, `w2` high in cycles 4–7;
   - `t3` high in cycles 2 and 6;
   - `cyc_end` in cycle 7;
   - `w1` high again from cycle 8.
2. `short`=1 held. Expected: `w1` high continuously, `cyc_end` every 4 cycles (3, 7, 11), `w2` never high. Additionally, raise `long` with `short` at the end of W1: behaviour is unchanged.
3. `long`=1 held. Expected: `w1` in cycles 0–3, `w2` in 4–7, `w3` in 8–11, `cyc_end` in cycle 11, next `w1` at cycle 12.
4. `stop` pulsed during W1 phase 1 only, then `stop` held from W2 phase 3. Expected:
   - the pulse is ignored;
   - with `stop` held, `cyc_end` occurs in cycle 7 and `running`=0 from cycle 8;
   - `qd` at cycle 10 restarts the sequence with `w1` from cycle 10.
5. `step`=1. Expected: each `qd` yields exactly one machine cycle followed by IDLE. A `qd` issued during W2 is ignored, with no extra cycle.
6. `clr` pulled low during W2 phase 1. Expected: all outputs are 0 asynchronously, before the next edge. After release, the generator stays in IDLE until `qd`.

Source files
------------

// File: rtl/cpu_timing_pkg.sv
// Shared types and defaults for the CPU beat/phase timing generator.
// Beat encoding and the beat-to-strobe mapping live here.
package cpu_timing_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        W1   = 2'd1,
        W2   = 2'd2,
        W3   = 2'd3
    } beat_e;

    localparam int unsigned DEF_PHASES   = 4;
    localparam int unsigned DEF_T3_PHASE = 2;

    // Map a beat to its {w3,w2,w1} strobe pattern; IDLE is all zero.
    function automatic logic [2:0] beat_onehot(input beat_e b);
        logic [2:0] oh;
        oh = 3'b000;
        unique case (b)
            IDLE: oh = 3'b000;
            W1:   oh = 3'b001;
            W2:   oh = 3'b010;
            W3:   oh = 3'b100;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/cpu_timing_gen_phase_counter.sv
// Modulo-PHASES phase counter with enable and synchronous clear.
// Flags the last phase of a beat so the FSM can take its decision.
module phase_counter #(
    parameter int unsigned PHASES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       sclr,
    output logic [3:0] phase,
    output logic       last
);

    localparam logic [3:0] LAST_PH = 4'(PHASES - 1);

    logic [3:0] phase_d;
    logic [3:0] phase_q;

    assign phase = phase_q;
    assign last  = (phase_q == LAST_PH);

    // Next phase: clear wins, otherwise wrap after the last phase.
    always_comb begin
        phase_d = phase_q;
        if (sclr) begin
            phase_d = 4'd0;
        end else if (en) begin
            phase_d = last ? 4'd0 : phase_q + 4'd1;
        end
    end

    // Phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 4'd0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/cpu_timing_gen.sv
// Beat FSM for the hardwired controller: sizes each machine cycle
// from short/long feedback and halts on stop/step at cycle end.
module cpu_timing_gen
    import cpu_timing_pkg::*;
#(
    parameter int unsigned PHASES   = DEF_PHASES,
    parameter int unsigned T3_PHASE = DEF_T3_PHASE
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       qd,
    input  logic       step,
    input  logic       short,
    input  logic       long,
    input  logic       stop,
    output logic       w1,
    output logic       w2,
    output logic       w3,
    output logic       t3,
    output logic [3:0] phase,
    output logic       running,
    output logic       cyc_end
);

    localparam logic [3:0] T3_PH = 4'(T3_PHASE);

    beat_e      state_d;
    beat_e      state_q;
    logic [2:0] w_q;
    logic       last;
    logic       end_mc;

    phase_counter #(
        .PHASES (PHASES)
    ) u_phase (
        .clk   (clk),
        .rst_n (clr),
        .en    (running),
        .sclr  (!running),
        .phase (phase),
        .last  (last)
    );

    assign running = (state_q != IDLE);
    assign t3      = running && (phase == T3_PH);
    assign cyc_end = end_mc;
    assign w1      = w_q[0];
    assign w2      = w_q[1];
    assign w3      = w_q[2];

    // Beat sequencing; feedback is only looked at on the last phase.
    always_comb begin
        state_d = state_q;
        end_mc  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (qd) state_d = W1;
            end
            W1: begin
                if (last) begin
                    if (short) end_mc = 1'b1;
                    else       state_d = W2;
                end
            end
            W2: begin
                if (last) begin
                    if (long) state_d = W3;
                    else      end_mc = 1'b1;
                end
            end
            W3: begin
                if (last) end_mc = 1'b1;
            end
        endcase
        if (end_mc) begin
            state_d = (stop || step) ? IDLE : W1;
        end
    end

    // State and beat strobes, registered together so they always agree.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            w_q     <= 3'b000;
        end else begin
            state_q <= state_d;
            w_q     <= beat_onehot(state_d);
        end
    end

endmodule

// File: tb/tb_cpu_timing_gen.sv
// Self-checking bench for cpu_timing_gen: directed scenarios plus
// random feedback, compared against a tick-count reference model.
module tb_cpu_timing_gen;

    localparam int P  = 4;
    localparam int T3 = 2;

    logic       clk;
    logic       clr;
    logic       qd;
    logic       step;
    logic       short;
    logic       long;
    logic       stop;
    logic       w1;
    logic       w2;
    logic       w3;
    logic       t3;
    logic [3:0] phase;
    logic       running;
    logic       cyc_end;

    int checks;
    int errors;
    int ce_cnt;

    // Reference: active flag plus ticks since machine-cycle start.
    bit m_act;
    int m_tick;

    cpu_timing_gen #(
        .PHASES   (P),
        .T3_PHASE (T3)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .qd      (qd),
        .step    (step),
        .short   (short),
        .long    (long),
        .stop    (stop),
        .w1      (w1),
        .w2      (w2),
        .w3      (w3),
        .t3      (t3),
        .phase   (phase),
        .running (running),
        .cyc_end (cyc_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_end();
        int b;
        b = m_tick / P;
        return (b == 0 && short) || (b == 1 && !long) || (b == 2);
    endfunction

    task automatic drv(input bit q, input bit st, input bit sh,
                       input bit lg, input bit sp);
        qd    = q;
        step  = st;
        short = sh;
        long  = lg;
        stop  = sp;
    endtask

    // Check mid-cycle, then advance the model on the same edge as the DUT.
    task automatic cyc();
        int  b;
        int  ph;
        bit  last;
        @(negedge clk);
        b    = m_tick / P;
        ph   = m_tick % P;
        last = m_act && (ph == P - 1);
        chk("w1", 32'(w1), 32'(m_act && b == 0));
        chk("w2", 32'(w2), 32'(m_act && b == 1));
        chk("w3", 32'(w3), 32'(m_act && b == 2));
        chk("phase", 32'(phase), m_act ? ph : 0);
        chk("t3", 32'(t3), 32'(m_act && ph == T3));
        chk("running", 32'(running), 32'(m_act));
        chk("cyc_end", 32'(cyc_end), 32'(last && m_end()));
        if (cyc_end) ce_cnt++;
        @(posedge clk);
        if (clr) begin
            if (!m_act) begin
                if (qd) begin
                    m_act  = 1'b1;
                    m_tick = 0;
                end
            end else if (m_tick % P == P - 1 && m_end()) begin
                if (stop || step) m_act = 1'b0;
                m_tick = 0;
            end else begin
                m_tick++;
            end
        end
        #1;
    endtask

    task automatic go_idle();
        drv(0, 0, 0, 0, 1);
        for (int i = 0; i < 16 && m_act; i++) cyc();
        cyc();
        chk("go_idle", 32'(running), 32'd0);
        drv(0, 0, 0, 0, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ce_cnt = 0;
        m_act  = 1'b0;
        m_tick = 0;
        clr    = 1'b0;
        drv(0, 0, 0, 0, 0);
        cyc();
        cyc();
        clr = 1'b1;
        cyc();

        // 1: normal W1,W2 cycles back to back
        drv(1, 0, 0, 0, 0);
        cyc();
        drv(0, 0, 0, 0, 0);
        ce_cnt = 0;
        repeat (12) cyc();
        chk("s1_ce_count", ce_cnt, 1);
        go_idle();

        // 2: short held, then long raised alongside short
        drv(1, 0, 1, 0, 0);
        cyc();
        drv(0, 0, 1, 0, 0);
        ce_cnt = 0;
        repeat (12) cyc();
        chk("s2_ce_count", ce_cnt, 3);
        drv(0, 0, 1, 1, 0);
        ce_cnt = 0;
        repeat (8) cyc();
        chk("s2_short_wins", ce_cnt, 2);
        go_idle();

        // 3: long held
        drv(1, 0, 0, 1, 0);
        cyc();
        drv(0, 0, 0, 1, 0);
        ce_cnt = 0;
        repeat (13) cyc();
        chk("s3_ce_count", ce_cnt, 1);
        chk("s3_w1_again", 32'(w1), 32'd1);
        go_idle();

        // 4: stop pulse in W1 ignored, stop held from W2 last phase
        drv(1, 0, 0, 0, 0);
        cyc();
        drv(0, 0, 0, 0, 0);
        cyc();
        drv(0, 0, 0, 0, 1);
        cyc();
        drv(0, 0, 0, 0, 0);
        repeat (5) cyc();
        drv(0, 0, 0, 0, 1);
        cyc();
        repeat (2) cyc();
        chk("s4_halted", 32'(running), 32'd0);
        drv(1, 0, 0, 0, 0);
        cyc();
        drv(0, 0, 0, 0, 0);
        repeat (8) cyc();
        go_idle();

        // 5: single-step, qd during W2 ignored
        drv(1, 1, 0, 0, 0);
        cyc();
        drv(0, 1, 0, 0, 0);
        repeat (10) cyc();
        drv(1, 1, 0, 0, 0);
        cyc();
        drv(0, 1, 0, 0, 0);
        repeat (4) cyc();
        drv(1, 1, 0, 0, 0);
        cyc();
        drv(0, 1, 0, 0, 0);
        ce_cnt = 0;
        repeat (6) cyc();
        chk("s5_one_cycle", ce_cnt, 1);
        chk("s5_idle", 32'(running), 32'd0);
        drv(0, 0, 0, 0, 0);

        // 6: asynchronous reset during W2 phase 1
        drv(1, 0, 0, 0, 0);
        cyc();
        drv(0, 0, 0, 0, 0);
        repeat (5) cyc();
        chk("s6_pre_w2", 32'(w2), 32'd1);
        clr = 1'b0;
        #1;
        chk("s6_rst_w", 32'({w3, w2, w1}), 32'd0);
        chk("s6_rst_phase", 32'(phase), 32'd0);
        chk("s6_rst_t3", 32'(t3), 32'd0);
        chk("s6_rst_run", 32'(running), 32'd0);
        chk("s6_rst_ce", 32'(cyc_end), 32'd0);
        m_act  = 1'b0;
        m_tick = 0;
        repeat (2) cyc();
        clr = 1'b1;
        repeat (3) cyc();
        drv(1, 0, 0, 0, 0);
        cyc();
        drv(0, 0, 0, 0, 0);
        repeat (8) cyc();

        // Random feedback against the model
        for (int i = 0; i < 3000; i++) begin
            drv(($urandom % 8) == 0, ($urandom % 16) == 0,
                ($urandom % 3) == 0, ($urandom % 2) == 0,
                ($urandom % 10) == 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
